// File: rtl/blinking_pkg.sv
// Shared types and default constants for the blinking machine's input conditioning.
package blinking_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } deb_state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int LONG_CYCLES_DEF     = 50_000_000;
    localparam int SYNC_STAGES_DEF     = 2;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/start_debouncer_btn_sync.sv
// btn_sync: SYNC_STAGES-deep flop chain bringing an asynchronous level into i_clk.
module btn_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] sync_p;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = sync_p[SYNC_STAGES-1];

endmodule

// File: rtl/start_debouncer.sv
// Start push-button conditioner: synchroniser, debounce FSM, single-cycle press pulse.
// Optional long-press pulse is built only when LONG_PRESS_EN is defined.
module start_debouncer
    import blinking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_button,
    output logic o_start,
    output logic o_level,
    output logic o_long_press
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || SYNC_STAGES < 2 || LONG_CYCLES < 2) begin : g_param_check
        $error("start_debouncer: DEBOUNCE_CYCLES, SYNC_STAGES and LONG_CYCLES must be >= 2");
    end

    logic             s_btn;
    deb_state_t       state;
    deb_state_t       next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             start_nxt;
    logic             level_nxt;

    btn_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_btn_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_async(i_button),
        .o_sync (s_btn)
    );

    // State register; outputs are registered alongside so they change with the state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            o_start <= 1'b0;
            o_level <= 1'b0;
        end else begin
            state   <= next_state;
            cnt     <= cnt_nxt;
            o_start <= start_nxt;
            o_level <= level_nxt;
        end
    end

    // Next state; every exit clears cnt so it can never wrap.
    always_comb begin
        next_state = state;
        cnt_nxt    = cnt;
        unique case (state)
            IDLE: begin
                if (s_btn) begin
                    next_state = PRESS_WAIT;
                    cnt_nxt    = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s_btn) begin
                    next_state = IDLE;
                    cnt_nxt    = '0;
                end else if (cnt == CNT_LAST) begin
                    next_state = PRESSED;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!s_btn) begin
                    next_state = RELEASE_WAIT;
                    cnt_nxt    = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s_btn) begin
                    next_state = PRESSED;
                    cnt_nxt    = '0;
                end else if (cnt == CNT_LAST) begin
                    next_state = IDLE;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                next_state = IDLE;
                cnt_nxt    = '0;
            end
        endcase
    end

    // Pulse only on a qualified press, never on a release-bounce return to PRESSED.
    always_comb begin
        start_nxt = (state == PRESS_WAIT) && (next_state == PRESSED);
        level_nxt = (next_state == PRESSED) || (next_state == RELEASE_WAIT);
    end

`ifdef LONG_PRESS_EN
    localparam int                LCNT_W    = cnt_width(LONG_CYCLES);
    localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LONG_CYCLES - 1);

    logic [LCNT_W-1:0] lcnt;
    logic              long_done;

    function automatic logic [LCNT_W-1:0] lcnt_sat_inc(input logic [LCNT_W-1:0] v);
        return (v == LCNT_LAST) ? v : v + LCNT_W'(1);
    endfunction

    // Held-time counter survives release bounces; long_done limits it to one pulse per press.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lcnt         <= '0;
            long_done    <= 1'b0;
            o_long_press <= 1'b0;
        end else if (start_nxt) begin
            lcnt         <= '0;
            long_done    <= 1'b0;
            o_long_press <= 1'b0;
        end else if (state == PRESSED && !long_done) begin
            lcnt         <= lcnt_sat_inc(lcnt);
            long_done    <= (lcnt == LCNT_LAST);
            o_long_press <= (lcnt == LCNT_LAST);
        end else begin
            o_long_press <= 1'b0;
        end
    end
`else
    assign o_long_press = 1'b0;
`endif

endmodule

// File: tb/tb_start_debouncer.sv
// Bench for start_debouncer (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, LONG_CYCLES=10).
module tb_start_debouncer;

    localparam int DEB  = 4;
    localparam int SYNC = 2;
    localparam int LONG = 10;
`ifdef LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic i_button = 1'b0;
    logic o_start;
    logic o_level;
    logic o_long_press;

    int errors = 0;
    int checks = 0;

    // Reference model state: recent raw samples, debounced level, run of disagreeing samples.
    bit [SYNC-1:0] m_hist;
    bit m_level;
    int m_run;
    int m_hold;
    bit m_long_done;
    logic exp_start, exp_level, exp_long;

    start_debouncer #(
        .DEBOUNCE_CYCLES(DEB),
        .SYNC_STAGES    (SYNC),
        .LONG_CYCLES    (LONG)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_button    (i_button),
        .o_start     (o_start),
        .o_level     (o_level),
        .o_long_press(o_long_press)
    );

    always #5 i_clk = ~i_clk;

    // A press or release is accepted once the synchronised input has disagreed with the
    // debounced level for DEB+1 consecutive edges (one edge to notice, DEB to qualify).
    task automatic model_edge(input bit btn, input bit rst);
        bit sb;
        bit was_pressed;
        exp_start = 1'b0;
        exp_long  = 1'b0;
        if (rst) begin
            m_hist = '0;
            m_level = 1'b0;
            m_run = 0;
            m_hold = 0;
            m_long_done = 1'b0;
        end else begin
            sb = m_hist[SYNC-1];
            was_pressed = m_level && (m_run == 0);
            if (LONG_EN && was_pressed && !m_long_done) begin
                m_hold++;
                if (m_hold == LONG) begin
                    exp_long = 1'b1;
                    m_long_done = 1'b1;
                end
            end
            if (sb != m_level) begin
                m_run++;
                if (m_run == DEB + 1) begin
                    m_level = sb;
                    m_run = 0;
                    if (sb) begin
                        exp_start = 1'b1;
                        m_hold = 0;
                        m_long_done = 1'b0;
                    end
                end
            end else begin
                m_run = 0;
            end
            m_hist = {m_hist[SYNC-2:0], btn};
        end
        exp_level = m_level;
    endtask

    task automatic tick(input bit btn, input bit rst);
        i_button = btn;
        i_rst = rst;
        @(posedge i_clk);
        model_edge(btn, rst);
        #1;
    endtask

    task automatic go_idle();
        for (int i = 0; i < 2; i++) tick(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        int first;
        first = -1;
        for (int i = 1; i <= 10; i++) begin
            tick(1'b1, 1'b1);
            checks++;
            if ({o_start, o_level, o_long_press} !== 3'b000) begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d got start/level/long=%b%b%b want 000",
                         i, o_start, o_level, o_long_press);
            end
        end
        for (int i = 1; i <= 10; i++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (o_start !== exp_start || o_level !== exp_level) begin
                errors++;
                $display("FAIL reset_release edge=%0d got start=%b level=%b want start=%b level=%b",
                         i, o_start, o_level, exp_start, exp_level);
            end
            if (o_start === 1'b1 && first < 0) first = i;
        end
        checks++;
        if (first != SYNC + DEB + 1) begin
            errors++;
            $display("FAIL reset_first_pulse got edge=%0d want %0d", first, SYNC + DEB + 1);
        end
    endtask

    task automatic test_clean_press();
        int first, pulses, fall;
        first = -1; pulses = 0; fall = -1;
        go_idle();
        for (int i = 1; i <= 20; i++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (o_start !== exp_start || o_level !== exp_level || o_long_press !== exp_long) begin
                errors++;
                $display("FAIL clean_press edge=%0d got %b%b%b want %b%b%b", i,
                         o_start, o_level, o_long_press, exp_start, exp_level, exp_long);
            end
            if (o_start === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (first != 7 || pulses != 1) begin
            errors++;
            $display("FAIL clean_press_pulse got edge=%0d count=%0d want edge=7 count=1", first, pulses);
        end
        for (int i = 1; i <= 10; i++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (o_start !== 1'b0 || o_level !== exp_level) begin
                errors++;
                $display("FAIL clean_release edge=%0d got start=%b level=%b want start=0 level=%b",
                         i, o_start, o_level, exp_level);
            end
            if (o_level === 1'b0 && fall < 0) fall = i;
        end
        checks++;
        if (fall != 7) begin
            errors++;
            $display("FAIL clean_release_fall got edge=%0d want 7", fall);
        end
    endtask

    task automatic test_press_bounce();
        bit pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int first, pulses;
        first = -1; pulses = 0;
        go_idle();
        for (int i = 0; i < 6; i++) begin
            tick(pat[i], 1'b0);
            checks++;
            if (o_start !== 1'b0 || o_level !== exp_level) begin
                errors++;
                $display("FAIL press_bounce step=%0d got start=%b level=%b want start=0 level=%b",
                         i, o_start, o_level, exp_level);
            end
        end
        for (int i = 1; i <= 15; i++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (o_start !== exp_start || o_level !== exp_level) begin
                errors++;
                $display("FAIL press_bounce_settle edge=%0d got start=%b level=%b want start=%b level=%b",
                         i, o_start, o_level, exp_start, exp_level);
            end
            if (o_start === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (first != 7 || pulses != 1) begin
            errors++;
            $display("FAIL press_bounce_pulse got edge=%0d count=%0d want edge=7 count=1", first, pulses);
        end
    endtask

    task automatic test_release_bounce();
        int fall;
        fall = -1;
        go_idle();
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick((i < 2) ? 1'b0 : 1'b1, 1'b0);
            checks++;
            if (o_start !== 1'b0 || o_level !== 1'b1 || o_level !== exp_level) begin
                errors++;
                $display("FAIL release_bounce step=%0d got start=%b level=%b want start=0 level=1",
                         i, o_start, o_level);
            end
        end
        for (int i = 1; i <= 10; i++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (o_start !== 1'b0 || o_level !== exp_level) begin
                errors++;
                $display("FAIL release_after_bounce edge=%0d got start=%b level=%b want start=0 level=%b",
                         i, o_start, o_level, exp_level);
            end
            if (o_level === 1'b0 && fall < 0) fall = i;
        end
        checks++;
        if (fall != 7) begin
            errors++;
            $display("FAIL release_after_bounce_fall got edge=%0d want 7", fall);
        end
    endtask

    task automatic test_mid_reset();
        int first;
        first = -1;
        go_idle();
        for (int i = 1; i <= 4; i++) begin
            tick(1'b1, (i == 4));
            checks++;
            if (o_start !== 1'b0 || o_level !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_pre edge=%0d got start=%b level=%b want 0 0", i, o_start, o_level);
            end
        end
        for (int i = 1; i <= 12; i++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (o_start !== exp_start || o_level !== exp_level) begin
                errors++;
                $display("FAIL mid_reset_post edge=%0d got start=%b level=%b want start=%b level=%b",
                         i, o_start, o_level, exp_start, exp_level);
            end
            if (o_start === 1'b1 && first < 0) first = i;
        end
        checks++;
        if (first != 7) begin
            errors++;
            $display("FAIL mid_reset_pulse got edge=%0d want 7", first);
        end
    endtask

    task automatic test_long_press();
        int first, pulses, want_edge, want_cnt;
        first = -1; pulses = 0;
        want_edge = LONG_EN ? (7 + LONG) : -1;
        want_cnt = LONG_EN ? 1 : 0;
        go_idle();
        for (int i = 1; i <= 30; i++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (o_long_press !== exp_long || o_start !== exp_start || o_level !== exp_level) begin
                errors++;
                $display("FAIL long_press edge=%0d got %b%b%b want %b%b%b", i,
                         o_start, o_level, o_long_press, exp_start, exp_level, exp_long);
            end
            if (o_long_press === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (first != want_edge || pulses != want_cnt) begin
            errors++;
            $display("FAIL long_press_pulse got edge=%0d count=%0d want edge=%0d count=%0d",
                     first, pulses, want_edge, want_cnt);
        end
    endtask

    task automatic test_random();
        bit btn, rst;
        int seg;
        btn = 1'b0;
        seg = 0;
        go_idle();
        for (int i = 0; i < 1500; i++) begin
            if (seg == 0) begin
                btn = ~btn;
                seg = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 25);
            end
            seg--;
            rst = ($urandom_range(0, 199) == 0);
            tick(btn, rst);
            checks++;
            if (o_start !== exp_start || o_level !== exp_level || o_long_press !== exp_long) begin
                errors++;
                $display("FAIL random cyc=%0d btn=%b rst=%b got %b%b%b want %b%b%b", i, btn, rst,
                         o_start, o_level, o_long_press, exp_start, exp_level, exp_long);
            end
        end
    endtask

    initial begin
        m_hist = '0; m_level = 1'b0; m_run = 0; m_hold = 0; m_long_done = 1'b0;
        exp_start = 1'b0; exp_level = 1'b0; exp_long = 1'b0;
        test_reset();
        test_clean_press();
        test_press_bounce();
        test_release_bounce();
        test_mid_reset();
        test_long_press();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
